// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The FIFO connects to the slave modport and the producer/consumer to the master modport.
interface sync_fifo_flags_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic              clr_err;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, wr_data, rd_en, clr_err,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             level, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en, clr_err,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             level, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy/threshold flags and sticky overflow/underflow errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; standard registered read otherwise.
module sync_fifo_flags #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AF_LVL = 14,
   parameter int AE_LVL = 2
) (
   input logic              clk,
   input logic              rst_n,
   sync_fifo_flags_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LVL_AF   = (ADDR_W+1)'(AF_LVL);
   localparam logic [ADDR_W:0] LVL_AE   = (ADDR_W+1)'(AE_LVL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   level_q;
   logic              overflow_q;
   logic              underflow_q;
   logic              full;
   logic              empty;
   logic              wr_acc;
   logic              rd_acc;

   // Flags come straight from the registered count, never from pointer compares.
   assign full   = (level_q == LVL_FULL);
   assign empty  = (level_q == '0);
   assign wr_acc = bus.wr_en && !full;
   assign rd_acc = bus.rd_en && !empty;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // A new error in the same cycle as clr_err wins, so the flag stays set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= (bus.wr_en && full)  || (overflow_q  && !bus.clr_err);
         underflow_q <= (bus.rd_en && empty) || (underflow_q && !bus.clr_err);
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign bus.rd_data  = empty ? '0 : mem[rd_ptr];
   assign bus.rd_valid = !empty;
`else
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) begin
            rd_data_q <= mem[rd_ptr];
         end
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
`endif

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (level_q >= LVL_AF);
   assign bus.almost_empty = (level_q <= LVL_AE);
   assign bus.level        = level_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule
